tpu_host_sequencer: RTL
=======================

Name: tpu_host_sequencer

Overview:
- Host-side initiator for the TPU core's load/compute/readout control interface; the core's controller is the responder.
- Accepts a byte stream of operands (A then B, 2x2 each, row-major), drives load_en/load_sel_ab/load_index/in_data, waits for done, then reads the 4 result bytes via output_en/output_sel.
- Re-emits the results as a valid/ready byte stream with a last flag.
- Sits between the chip-level pin adapter and the TPU controller; also used as the bench-side driver.

Parameters:
- DONE_TIMEOUT, 255, max cycles to wait for done before flagging an error; counter width = $clog2(DONE_TIMEOUT+1).
- READ_LATENCY, 1, cycles from output_en assertion to valid out_data (1..3).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  operand byte valid
- s_ready  out  1  operand byte accepted when s_valid && s_ready
- s_data  in  8  operand byte
- load_en  out  1  one-cycle strobe; core latches in_data
- load_sel_ab  out  1  0 = matrix A, 1 = matrix B
- load_index  out  2  element index 0..3
- in_data  out  8  element value
- done  in  1  core result ready (level)
- output_en  out  1  one-cycle read strobe
- output_sel  out  2  result element 0..3
- out_data  in  8  result byte, valid READ_LATENCY cycles after output_en
- m_valid  out  1  result byte valid
- m_ready  in  1  downstream accepts
- m_data  out  8  result byte
- m_last  out  1  high with the 4th result byte
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; cleared only by reset or the next accepted operand byte

Behaviour:
- Reset (rst_n low at a clk edge) sampled synchronously; every output goes to 0 and the FSM enters IDLE. Reset mid-transfer abandons the transaction; the partial load is not resumed.
- All outputs registered.
- States: IDLE, LOAD, WAIT_DONE, READ_REQ, READ_WAIT, EMIT.
- IDLE:
  - s_ready=1.
  - On s_valid: drive load_en=1, load_sel_ab=0, load_index=0, in_data=s_data next cycle; clear timeout_err; set elem=1; go to LOAD.
- LOAD:
  - s_ready=1; each accepted byte produces exactly one load_en cycle.
  - The element counter elem[2:0] maps as load_sel_ab=elem[2], load_index=elem[1:0].
  - Gaps in s_valid produce load_en=0 cycles; sel/index hold.
  - After the byte with elem=7 is accepted, go to WAIT_DONE; s_ready=0 from then until return to IDLE.
- WAIT_DONE:
  - Counter counts cycles.
  - done=1 -> READ_REQ with sel=0.
  - Counter reaching DONE_TIMEOUT with done=0 -> set timeout_err, go to IDLE, emit no results.
  - done already high on WAIT_DONE entry is accepted on the first cycle.
- READ_REQ: output_en=1 for exactly one cycle with output_sel=sel, then READ_WAIT.
- READ_WAIT:
  - Wait READ_LATENCY cycles, capture out_data into m_data, go to EMIT.
  - Total per-byte read latency = READ_LATENCY+1 cycles from entering READ_REQ to capture.
- EMIT:
  - m_valid=1; m_last=(sel==3); m_data stable while m_valid && !m_ready.
  - On handshake: if sel==3, go to IDLE (m_valid drops the next cycle); else sel++ and go to READ_REQ.
  - m_ready held low stalls indefinitely; no timeout applies in EMIT.
- Protocol invariants:
  - load_en and output_en never high in the same cycle.
  - output_en only after done was seen.
  - load_index/output_sel wrap is impossible by construction (counters stop at 7/3).
- Back-to-back: a new operand byte may be accepted in the cycle after the m_last handshake (first cycle of IDLE).

Decomposition:
- Package tpu_pkg:
  - FSM state enum.
  - NUM_ELEMS=4, NUM_LOADS=8, DATA_W=8.
  - Constants SEL_A=0, SEL_B=1.
- One natural sub-module: tpu_timeout_ctr (loadable down-counter with expire flag), reused for the WAIT_DONE timeout.
- All other logic stays in the top FSM.

Test Plan:
- Stream bytes 1,2,3,4,5,6,7,8 with s_valid continuous:
  - load_en pulses 8 consecutive cycles.
  - (sel,index,data) = (0,0,1)..(0,3,4),(1,0,5)..(1,3,8).
  - s_ready low afterwards.
- Same stream with s_valid toggling every other cycle: exactly 8 load_en pulses, values unchanged, no duplicate loads.
- Responder model with A=[1,2,3,4], B=[5,6,7,8], done 10 cycles after the last load, READ_LATENCY=1:
  - m_data = 19,22,43,50 (low 8 bits); m_last only on 50.
  - output_en pulses with sel 0,1,2,3.
- m_ready low for 5 cycles during the 2nd result: m_valid held, m_data=22 stable, no extra output_en issued.
- done never asserted:
  - timeout_err=1 at cycle DONE_TIMEOUT after WAIT_DONE entry; back in IDLE; m_valid never high.
  - The next operand byte clears timeout_err.
- rst_n low for one cycle during the 5th load and during EMIT:
  - All outputs 0, busy=0 the next cycle.
  - A fresh 8-byte transfer then completes normally.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU host-side sequencer.
package tpu_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_ELEMS = 4;
  localparam int NUM_LOADS = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_READ_REQ  = 3'd3,
    ST_READ_WAIT = 3'd4,
    ST_EMIT      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/tpu_timeout_ctr.sv
// Loadable down-counter; expired is high while the count sits at zero.
module tpu_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/tpu_host_sequencer.sv
// Host initiator for the TPU load/compute/readout interface.
// Handshakes: a byte moves on s_* / m_* only in a cycle where valid && ready are both high.
module tpu_host_sequencer
  import tpu_pkg::*;
#(
  parameter int DONE_TIMEOUT = 255,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              load_en,
  output logic              load_sel_ab,
  output logic [1:0]        load_index,
  output logic [DATA_W-1:0] in_data,
  input  logic              done,
  output logic              output_en,
  output logic [1:0]        output_sel,
  input  logic [DATA_W-1:0] out_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              timeout_err,
  output seq_state_e        state_dbg
);

  localparam int         TW        = $clog2(DONE_TIMEOUT + 1);
  localparam logic [2:0] LAST_LOAD = 3'(NUM_LOADS - 1);
  localparam logic [1:0] LAST_ELEM = 2'(NUM_ELEMS - 1);
  localparam logic [1:0] RL_INIT   = 2'(READ_LATENCY - 1);

  seq_state_e state;
  logic [2:0] elem;
  logic [1:0] sel;
  logic [1:0] rl_cnt;
  logic       s_fire;
  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_expired;

  assign s_fire    = s_valid && s_ready;
  assign tmr_load  = (state == ST_LOAD) && s_fire && (elem == LAST_LOAD);
  assign tmr_dec   = (state == ST_WAIT_DONE);
  assign state_dbg = state;

  // Loaded with DONE_TIMEOUT-1 so expiry lands exactly DONE_TIMEOUT cycles after entry.
  tpu_timeout_ctr #(.W(TW)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TW'(DONE_TIMEOUT - 1)),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      elem        <= '0;
      sel         <= '0;
      rl_cnt      <= '0;
      s_ready     <= 1'b0;
      load_en     <= 1'b0;
      load_sel_ab <= SEL_A;
      load_index  <= '0;
      in_data     <= '0;
      output_en   <= 1'b0;
      output_sel  <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      load_en   <= 1'b0;
      output_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          if (s_fire) begin
            load_en     <= 1'b1;
            load_sel_ab <= SEL_A;
            load_index  <= 2'd0;
            in_data     <= s_data;
            timeout_err <= 1'b0;
            elem        <= 3'd1;
            busy        <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (s_fire) begin
            load_en     <= 1'b1;
            load_sel_ab <= elem[2];
            load_index  <= elem[1:0];
            in_data     <= s_data;
            if (elem == LAST_LOAD) begin
              s_ready <= 1'b0;
              state   <= ST_WAIT_DONE;
            end else begin
              elem <= elem + 3'd1;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (done) begin
            sel        <= 2'd0;
            output_en  <= 1'b1;
            output_sel <= 2'd0;
            state      <= ST_READ_REQ;
          end else if (tmr_expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            s_ready     <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_READ_REQ: begin
          rl_cnt <= RL_INIT;
          state  <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          if (rl_cnt == 2'd0) begin
            m_data  <= out_data;
            m_valid <= 1'b1;
            m_last  <= (sel == LAST_ELEM);
            state   <= ST_EMIT;
          end else begin
            rl_cnt <= rl_cnt - 2'd1;
          end
        end
        ST_EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (sel == LAST_ELEM) begin
              busy    <= 1'b0;
              s_ready <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              sel        <= sel + 2'd1;
              output_en  <= 1'b1;
              output_sel <= sel + 2'd1;
              state      <= ST_READ_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
